amiq_i2c_ex_bus_model: RTL and testbench

//  N-agent I2C bus model for example benches. Resolves N agents' SDA/SCL drives
//  (wired-AND, optional push-pull contention check), then synchronises and deglitches the lines.

---
 rtl/amiq_i2c_ex_bus_model.sv | 166 ++++++++++++++++
 tb/tb_amiq_i2c_ex_bus_model.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amiq_i2c_ex_bus_model.sv
// N-agent I2C bus model: wired-AND resolution, sync + deglitch filter,
// START/STOP tracking, bit/byte position, arbitration loss and SCL-low timeout.
module amiq_i2c_ex_bus_model #(
  parameter int N_AGENTS       = 2,
  parameter int FILTER_LEN     = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16,
  parameter int PUSH_PULL      = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_AGENTS-1:0] sda_o,
  input  logic [N_AGENTS-1:0] sda_o_en,
  input  logic [N_AGENTS-1:0] scl_o,
  input  logic [N_AGENTS-1:0] scl_o_en,
  input  logic [N_AGENTS-1:0] master_mask,
  output logic                sda_bus,
  output logic                scl_bus,
  output logic                sda_filt,
  output logic                scl_filt,
  output logic                start_det,
  output logic                stop_det,
  output logic                bus_busy,
  output logic [3:0]          bit_cnt,
  output logic [CNT_W-1:0]    byte_cnt,
  output logic [N_AGENTS-1:0] arb_lost,
  output logic                contention,
  output logic                frame_err,
  output logic                scl_timeout
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0]   F_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [N_AGENTS-1:0] sda_pull, scl_pull;
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d;
  logic [1:0] prev_q;
  logic [1:0][FCW-1:0] fcnt_q, fcnt_d;

  logic start_ev, stop_ev, scl_rise, conflict;

  logic                busy_q, busy_d;
  logic [3:0]          bit_q, bit_d;
  logic [CNT_W-1:0]    byte_q, byte_d;
  logic [N_AGENTS-1:0] arb_q, arb_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                ferr_q, ferr_d;
  logic                cont_q, cont_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;

  // An agent only ever pulls low; a released or high-driving agent leaves the pull-up.
  assign sda_pull = sda_o_en & ~sda_o;
  assign scl_pull = scl_o_en & ~scl_o;
  assign sda_bus  = ~|sda_pull;
  assign scl_bus  = ~|scl_pull;
  assign raw      = {scl_bus, sda_bus};

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int l = 0; l < 2; l++) begin
      if (sync2_q[l] != filt_q[l]) begin
        if (fcnt_q[l] == F_LAST) filt_d[l] = sync2_q[l];
        else fcnt_d[l] = fcnt_q[l] + FCW'(1);
      end
    end
  end

  // Index 0 is SDA, index 1 is SCL throughout.
  assign start_ev = prev_q[1] & filt_q[1] &  prev_q[0] & ~filt_q[0];
  assign stop_ev  = prev_q[1] & filt_q[1] & ~prev_q[0] &  filt_q[0];
  assign scl_rise = ~prev_q[1] & filt_q[1];

  assign conflict = ((|(sda_o_en & sda_o)) & (|(sda_o_en & ~sda_o))) |
                    ((|(scl_o_en & scl_o)) & (|(scl_o_en & ~scl_o)));

  always_comb begin
    busy_d  = busy_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    arb_d   = arb_q;
    start_d = start_ev;
    stop_d  = stop_ev;
    ferr_d  = 1'b0;
    cont_d  = (PUSH_PULL != 0) && conflict;
    tcnt_d  = '0;

    if (start_ev) begin
      ferr_d = busy_q && (bit_q != 4'd0);
      if (!busy_q) begin
        byte_d = '0;
        arb_d  = '0;
      end
      busy_d = 1'b1;
      bit_d  = 4'd0;
    end else if (stop_ev) begin
      ferr_d = busy_q && (bit_q != 4'd0);
      busy_d = 1'b0;
      bit_d  = 4'd0;
    end else if (scl_rise && busy_q) begin
      // A master that released SDA but sees it low has lost the bit.
      arb_d = arb_q | (master_mask & ~sda_pull & {N_AGENTS{~filt_q[0]}});
      if (bit_q == 4'd8) begin
        bit_d = 4'd0;
        if (~&byte_q) byte_d = byte_q + CNT_W'(1);
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end

    if (busy_q && !filt_q[1]) begin
      tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      bit_q   <= 4'd0;
      byte_q  <= '0;
      arb_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cont_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      arb_q   <= arb_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      ferr_q  <= ferr_d;
      cont_q  <= cont_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign sda_filt    = filt_q[0];
  assign scl_filt    = filt_q[1];
  assign start_det   = start_q;
  assign stop_det    = stop_q;
  assign bus_busy    = busy_q;
  assign bit_cnt     = bit_q;
  assign byte_cnt    = byte_q;
  assign arb_lost    = arb_q;
  assign contention  = cont_q;
  assign frame_err   = ferr_q;
  assign scl_timeout = (tcnt_q >= TO_LIM);

endmodule

// File: tb/tb_amiq_i2c_ex_bus_model.sv
// Bench for amiq_i2c_ex_bus_model: directed protocol cases plus random transfers
// checked against a phase-level I2C event model.
module tb_amiq_i2c_ex_bus_model;

  localparam int FL   = 3;
  localparam int HOLD = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0] sda_pull = 2'b00, scl_pull = 2'b00, sda_val = 2'b00, mask = 2'b00;
  logic gl_sda = 1'b0, gl_scl = 1'b0;
  logic [1:0] sda_en_w, scl_en_w;
  logic [1:0] scl_val = 2'b00;
  assign sda_en_w = sda_pull | {gl_sda, 1'b0};
  assign scl_en_w = scl_pull | {gl_scl, 1'b0};

  logic sda_bus, scl_bus, sda_filt, scl_filt, start_det, stop_det, bus_busy;
  logic contention, frame_err, scl_timeout;
  logic [3:0] bit_cnt;
  logic [15:0] byte_cnt;
  logic [1:0] arb_lost;

  logic pp_sda_bus, pp_scl_bus, pp_sda_filt, pp_scl_filt, pp_start, pp_stop, pp_busy;
  logic pp_contention, pp_ferr, pp_timeout;
  logic [3:0] pp_bit_cnt;
  logic [15:0] pp_byte_cnt;
  logic [1:0] pp_arb;

  amiq_i2c_ex_bus_model #(.N_AGENTS(2), .FILTER_LEN(FL), .TIMEOUT_CYCLES(1000),
                          .CNT_W(16), .PUSH_PULL(0)) dut (
    .clock(clock), .reset(reset),
    .sda_o(sda_val), .sda_o_en(sda_en_w), .scl_o(scl_val), .scl_o_en(scl_en_w),
    .master_mask(mask),
    .sda_bus(sda_bus), .scl_bus(scl_bus), .sda_filt(sda_filt), .scl_filt(scl_filt),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
    .bit_cnt(bit_cnt), .byte_cnt(byte_cnt), .arb_lost(arb_lost),
    .contention(contention), .frame_err(frame_err), .scl_timeout(scl_timeout));

  amiq_i2c_ex_bus_model #(.N_AGENTS(2), .FILTER_LEN(FL), .TIMEOUT_CYCLES(1000),
                          .CNT_W(16), .PUSH_PULL(1)) dut_pp (
    .clock(clock), .reset(reset),
    .sda_o(sda_val), .sda_o_en(sda_en_w), .scl_o(scl_val), .scl_o_en(scl_en_w),
    .master_mask(mask),
    .sda_bus(pp_sda_bus), .scl_bus(pp_scl_bus), .sda_filt(pp_sda_filt), .scl_filt(pp_scl_filt),
    .start_det(pp_start), .stop_det(pp_stop), .bus_busy(pp_busy),
    .bit_cnt(pp_bit_cnt), .byte_cnt(pp_byte_cnt), .arb_lost(pp_arb),
    .contention(pp_contention), .frame_err(pp_ferr), .scl_timeout(pp_timeout));

  int n_chk = 0, n_fail = 0;
  int o_start = 0, o_stop = 0, o_ferr = 0;
  int e_start = 0, e_stop = 0, e_ferr = 0;

  logic m_sda, m_scl, m_busy;
  logic [3:0] m_bit;
  logic [15:0] m_byte;
  logic [1:0] m_arb;

  always @(negedge clock) begin
    if (start_det) o_start++;
    if (stop_det) o_stop++;
    if (frame_err) o_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sda = 1'b1; m_scl = 1'b1; m_busy = 1'b0;
    m_bit = 4'd0; m_byte = 16'd0; m_arb = 2'b00;
  endfunction

  // Protocol-level view: each call is one settled change of the bus lines.
  function automatic void model_step(input logic nsda, input logic nscl);
    if (m_scl && nscl && m_sda && !nsda) begin
      e_start++;
      if (m_busy && m_bit != 0) e_ferr++;
      if (!m_busy) begin m_byte = 16'd0; m_arb = 2'b00; end
      m_busy = 1'b1; m_bit = 4'd0;
    end else if (m_scl && nscl && !m_sda && nsda) begin
      e_stop++;
      if (m_busy && m_bit != 0) e_ferr++;
      m_busy = 1'b0; m_bit = 4'd0;
    end else if (!m_scl && nscl && m_busy) begin
      for (int i = 0; i < 2; i++)
        if (mask[i] && !sda_pull[i] && !nsda) m_arb[i] = 1'b1;
      if (m_bit == 8) begin
        m_bit = 4'd0;
        if (m_byte != 16'hFFFF) m_byte = m_byte + 16'd1;
      end else begin
        m_bit = m_bit + 4'd1;
      end
    end
    m_sda = nsda; m_scl = nscl;
  endfunction

  task automatic chk_all();
    chk("sda_bus", 32'(sda_bus), 32'(m_sda));
    chk("scl_bus", 32'(scl_bus), 32'(m_scl));
    chk("sda_filt", 32'(sda_filt), 32'(m_sda));
    chk("scl_filt", 32'(scl_filt), 32'(m_scl));
    chk("bus_busy", 32'(bus_busy), 32'(m_busy));
    chk("bit_cnt", 32'(bit_cnt), 32'(m_bit));
    chk("byte_cnt", 32'(byte_cnt), 32'(m_byte));
    chk("arb_lost", 32'(arb_lost), 32'(m_arb));
    chk("n_start", 32'(o_start), 32'(e_start));
    chk("n_stop", 32'(o_stop), 32'(e_stop));
    chk("n_frame_err", 32'(o_ferr), 32'(e_ferr));
    chk("contention_od", 32'(contention), 32'd0);
    chk("contention_pp", 32'(pp_contention), 32'd0);
    chk("scl_timeout", 32'(scl_timeout), 32'd0);
    chk("pp_busy", 32'(pp_busy), 32'(m_busy));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sda_filt"}, 32'(sda_filt), 32'd1);
    chk({tag, "_scl_filt"}, 32'(scl_filt), 32'd1);
    chk({tag, "_busy"}, 32'(bus_busy), 32'd0);
    chk({tag, "_bit"}, 32'(bit_cnt), 32'd0);
    chk({tag, "_byte"}, 32'(byte_cnt), 32'd0);
    chk({tag, "_arb"}, 32'(arb_lost), 32'd0);
    chk({tag, "_pulses"}, 32'({start_det, stop_det, frame_err}), 32'd0);
    chk({tag, "_timeout"}, 32'(scl_timeout), 32'd0);
  endtask

  // Wait for the change to settle, occasionally inject a sub-filter glitch, then check.
  task automatic settle();
    int g;
    repeat (HOLD) @(negedge clock);
    if ($urandom_range(0, 3) == 0) begin
      g = int'($urandom_range(1, FL - 1));
      if ($urandom_range(0, 1) == 1) gl_sda = 1'b1;
      else gl_scl = 1'b1;
      repeat (g) @(negedge clock);
      gl_sda = 1'b0; gl_scl = 1'b0;
      repeat (HOLD) @(negedge clock);
    end
    chk_all();
  endtask

  task automatic set_sda(input logic [1:0] p);
    @(negedge clock);
    sda_pull = p;
    model_step(~|sda_pull, ~|scl_pull);
    settle();
  endtask

  task automatic set_scl(input logic [1:0] p);
    @(negedge clock);
    scl_pull = p;
    model_step(~|sda_pull, ~|scl_pull);
    settle();
  endtask

  task automatic send_bit(input logic [1:0] p);
    set_scl(2'b01);
    set_sda(p);
    set_scl(2'b00);
  endtask

  task automatic rand_xfer();
    int nb, early;
    logic [7:0] d0, d1;
    logic [1:0] p;
    mask = 2'($urandom_range(0, 3));
    set_sda(2'b01);
    for (int seg = 0; seg < 2; seg++) begin
      nb = int'($urandom_range(1, 2));
      for (int b = 0; b < nb; b++) begin
        d0 = 8'($urandom);
        d1 = ($urandom_range(0, 1) == 1) ? d0 : 8'($urandom);
        early = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0;
        for (int k = 1; k <= 8; k++) begin
          p = {~d1[8-k], ~d0[8-k]};
          if (k == early) begin
            send_bit(p | 2'b01);
            set_sda(2'b00);
            return;
          end
          send_bit(p);
        end
        send_bit(2'($urandom_range(0, 3)));
      end
      if (m_sda == 1'b0) begin
        set_sda(2'b00);
        return;
      end
      if (seg == 0) set_sda(2'b01);
    end
    send_bit(2'b01);
    set_sda(2'b00);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] a85;
    a5 = 8'hA5;
    a85 = 8'h85;
    model_reset();
    repeat (3) @(posedge clock);
    #1 chk_reset("rst0");
    @(negedge clock) reset = 1'b0;

    repeat (100) @(negedge clock);
    chk_all();

    // START timing: raw fall to sda_filt takes 5 edges, pulse one cycle later.
    mask = 2'b00;
    @(negedge clock);
    sda_pull = 2'b01;
    model_step(~|sda_pull, ~|scl_pull);
    repeat (4) @(posedge clock);
    #1 chk("sda_filt_lag", 32'(sda_filt), 32'd1);
    @(posedge clock);
    #1 chk("sda_filt_fall", 32'(sda_filt), 32'd0);
    chk("start_early", 32'(start_det), 32'd0);
    @(posedge clock);
    #1 chk("start_det", 32'(start_det), 32'd1);
    chk("busy_start", 32'(bus_busy), 32'd1);
    settle();

    // Byte 0xA5 with ACK from agent 1, then STOP.
    for (int k = 0; k < 8; k++) send_bit({1'b0, ~a5[7-k]});
    send_bit(2'b10);
    chk("a5_byte_cnt", 32'(byte_cnt), 32'd1);
    chk("a5_bit_cnt", 32'(bit_cnt), 32'd0);
    set_sda(2'b00);
    chk("a5_stop", 32'(o_stop), 32'd1);
    chk("a5_ferr", 32'(o_ferr), 32'd0);

    // Arbitration: agent 0 releases at bit 3 while agent 1 pulls low.
    mask = 2'b11;
    set_sda(2'b01);
    for (int k = 0; k < 8; k++) send_bit({~a85[7-k], ~a5[7-k]});
    send_bit(2'b10);
    chk("arb_dir", 32'(arb_lost), 32'd1);
    set_sda(2'b00);
    chk("arb_sticky", 32'(arb_lost), 32'd1);

    // SCL timeout, then STOP at bit 4 is a frame error.
    mask = 2'b00;
    set_sda(2'b01);
    repeat (3) send_bit(2'b01);
    @(negedge clock);
    scl_pull = 2'b01;
    model_step(~|sda_pull, ~|scl_pull);
    repeat (1004) @(posedge clock);
    #1 chk("timeout_early", 32'(scl_timeout), 32'd0);
    @(posedge clock);
    #1 chk("timeout_set", 32'(scl_timeout), 32'd1);
    set_scl(2'b00);
    chk("timeout_clr", 32'(scl_timeout), 32'd0);
    chk("bit4", 32'(bit_cnt), 32'd4);
    set_sda(2'b00);
    chk("ferr_bit4", 32'(o_ferr), 32'd1);

    // Reset in the middle of a transfer.
    mask = 2'b11;
    set_sda(2'b01);
    send_bit(2'b10);
    send_bit(2'b01);
    @(negedge clock);
    reset = 1'b1;
    sda_pull = 2'b00;
    scl_pull = 2'b00;
    @(posedge clock);
    #1 chk_reset("rst_mid");
    @(negedge clock) reset = 1'b0;
    model_reset();
    settle();

    for (int t = 0; t < 20; t++) rand_xfer();

    // Push-pull contention on SDA.
    @(negedge clock);
    sda_val = 2'b01;
    sda_pull = 2'b11;
    #1 chk("cont_bus", 32'(sda_bus), 32'd0);
    chk("cont_pre", 32'(pp_contention), 32'd0);
    @(posedge clock);
    #1 chk("cont_pp", 32'(pp_contention), 32'd1);
    chk("cont_od", 32'(contention), 32'd0);
    @(negedge clock);
    sda_val = 2'b00;
    sda_pull = 2'b00;
    @(posedge clock);
    #1 chk("cont_clr", 32'(pp_contention), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
